// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the clock-gate enable sequencer.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    StOff  = 2'b00,
    StWake = 2'b01,
    StOn   = 2'b11,
    StHold = 2'b10
  } gate_state_e;

  localparam int unsigned CNT_MAX_W = 8;

  function automatic bit params_legal(input int unsigned num_req,
                                      input int unsigned wake_cycles,
                                      input int unsigned idle_cycles,
                                      input int unsigned cnt_w);
    return (num_req >= 1) && (wake_cycles >= 1) && (wake_cycles <= 15) &&
           (idle_cycles <= 255) && (cnt_w >= 1) && (cnt_w <= 32);
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_gate_timer.sv
// Loadable down-counter shared by the WAKE settle and HOLD idle windows.
module gate_timer
  import clk_gate_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [CNT_MAX_W-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 zero_o
);

  logic [CNT_MAX_W-1:0] count_q, count_d;

  assign zero_o = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable sequencer for the clock-gating cell: wake settle, idle hold, wake-event count.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               FORCE_ON,
  output logic               CLK_EN,
  output logic               CLK_RDY,
  output logic               BUSY,
  output logic [CNT_W-1:0]   WAKE_CNT
);

  if (!params_legal(NUM_REQ, WAKE_CYCLES, IDLE_CYCLES, CNT_W)) begin : g_param_check
    $error("clk_gate_ctrl: illegal parameter combination");
  end

  localparam logic [CNT_MAX_W-1:0] WakeLoad = CNT_MAX_W'(WAKE_CYCLES - 1);
  // HOLD spans IDLE_CYCLES+1 cycles before the gate closes, so the timer starts one higher.
  localparam logic [CNT_MAX_W-1:0] IdleLoad = CNT_MAX_W'(IDLE_CYCLES);

  gate_state_e          state_q, state_d;
  logic                 any_req;
  logic                 tmr_load, tmr_dec, tmr_zero;
  logic [CNT_MAX_W-1:0] tmr_load_val;
  logic                 en_q, rdy_q, busy_q;
  logic [CNT_W-1:0]     wake_cnt_q, wake_cnt_d;

  assign any_req = (|REQ) | FORCE_ON;

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_load_val = WakeLoad;
    unique case (state_q)
      StOff: begin
        if (any_req) begin
          state_d  = StWake;
          tmr_load = 1'b1;
        end
      end
      StWake: begin
        if (tmr_zero) begin
          state_d = StOn;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StOn: begin
        if (!any_req) begin
          if (IDLE_CYCLES == 0) begin
            state_d = StOff;
          end else begin
            state_d      = StHold;
            tmr_load     = 1'b1;
            tmr_load_val = IdleLoad;
          end
        end
      end
      StHold: begin
        if (any_req) begin
          state_d = StOn;
        end else if (tmr_zero) begin
          state_d = StOff;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = StOff;
    endcase
  end

  always_comb begin
    wake_cnt_d = wake_cnt_q;
    if ((state_q == StOff) && (state_d == StWake) && (wake_cnt_q != '1)) begin
      wake_cnt_d = wake_cnt_q + 1'b1;
    end
  end

  gate_timer u_timer (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StOff;
      en_q       <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= (state_d != StOff);
      rdy_q      <= (state_d == StOn) || (state_d == StHold);
      busy_q     <= (state_d != StOff);
      wake_cnt_q <= wake_cnt_d;
    end
  end

  assign CLK_EN   = en_q;
  assign CLK_RDY  = rdy_q;
  assign BUSY     = busy_q;
  assign WAKE_CNT = wake_cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench: two configurations driven in lockstep against a timeline reference model.
module tb_clk_gate_ctrl;

  typedef struct {
    bit open;
    bit ready;
    int t;
    int run;
    int wakes;
  } mdl_t;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       busy;
    logic [7:0] wcnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic       force_on;

  logic       en_a, rdy_a, busy_a;
  logic [7:0] wcnt_a;
  logic       en_b, rdy_b, busy_b;
  logic [1:0] wcnt_b;

  mdl_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];
  int   n_tests;
  int   n_fail;

  clk_gate_ctrl #(
    .NUM_REQ     (2),
    .WAKE_CYCLES (2),
    .IDLE_CYCLES (4),
    .CNT_W       (8)
  ) dut_a (
    .CLK      (clk),
    .RST      (rst_n),
    .REQ      (req),
    .FORCE_ON (force_on),
    .CLK_EN   (en_a),
    .CLK_RDY  (rdy_a),
    .BUSY     (busy_a),
    .WAKE_CNT (wcnt_a)
  );

  clk_gate_ctrl #(
    .NUM_REQ     (2),
    .WAKE_CYCLES (1),
    .IDLE_CYCLES (0),
    .CNT_W       (2)
  ) dut_b (
    .CLK      (clk),
    .RST      (rst_n),
    .REQ      (req),
    .FORCE_ON (force_on),
    .CLK_EN   (en_b),
    .CLK_RDY  (rdy_b),
    .BUSY     (busy_b),
    .WAKE_CNT (wcnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timeline view: gate opens on a request, is ready WAKE edges later, and closes once
  // requests have been low for the idle window (immediately when the window is zero).
  function automatic mdl_t mdl_step(input mdl_t s, input bit rn, input bit r,
                                    input int wake, input int idle, input int wmax);
    mdl_t n;
    n = s;
    if (!rn) begin
      n.open = 0; n.ready = 0; n.t = 0; n.run = 0; n.wakes = 0;
    end else if (!s.open) begin
      if (r) begin
        n.open = 1;
        n.t    = 0;
        if (s.wakes < wmax) n.wakes = s.wakes + 1;
      end
    end else if (!s.ready) begin
      n.t = s.t + 1;
      if (n.t >= wake) begin
        n.ready = 1;
        n.run   = 0;
      end
    end else begin
      n.run = r ? 0 : s.run + 1;
      if (n.run >= ((idle == 0) ? 1 : idle + 2)) begin
        n.open  = 0;
        n.ready = 0;
      end
    end
    return n;
  endfunction

  function automatic exp_t to_exp(input mdl_t s);
    exp_t e;
    e.en   = s.open;
    e.rdy  = s.ready;
    e.busy = s.open;
    e.wcnt = 8'(s.wakes);
    return e;
  endfunction

  task automatic check_out(input string name, input exp_t e, input logic en,
                           input logic rdy, input logic busy, input logic [7:0] wcnt);
    n_tests++;
    if (en !== e.en || rdy !== e.rdy || busy !== e.busy || wcnt !== e.wcnt) begin
      n_fail++;
      $display("FAIL %s @%0t: got en=%b rdy=%b busy=%b wcnt=%0d, expected en=%b rdy=%b busy=%b wcnt=%0d",
               name, $time, en, rdy, busy, wcnt, e.en, e.rdy, e.busy, e.wcnt);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check_out("dut_a", e, en_a, rdy_a, busy_a, wcnt_a);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check_out("dut_b", e, en_b, rdy_b, busy_b, {6'b0, wcnt_b});
    end
  end

  task automatic run(input logic [1:0] r, input logic f, input logic rn, input int n);
    bit any;
    for (int i = 0; i < n; i++) begin
      req      = r;
      force_on = f;
      rst_n    = rn;
      @(posedge clk);
      any = (|r) | f;
      ma = mdl_step(ma, rn, any, 2, 4, 255);
      mb = mdl_step(mb, rn, any, 1, 0, 3);
      qa.push_back(to_exp(ma));
      qb.push_back(to_exp(mb));
      #1;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ma = '{default: 0};
    mb = '{default: 0};
    // Reset held with a request pending, then release.
    run(2'b01, 1'b0, 1'b0, 3);
    run(2'b01, 1'b0, 1'b1, 5);
    run(2'b00, 1'b0, 1'b1, 10);
    // Six-cycle pulse on REQ[1].
    run(2'b10, 1'b0, 1'b1, 6);
    run(2'b00, 1'b0, 1'b1, 12);
    // Drop and re-raise inside HOLD.
    run(2'b11, 1'b0, 1'b1, 8);
    run(2'b00, 1'b0, 1'b1, 2);
    run(2'b01, 1'b0, 1'b1, 4);
    run(2'b00, 1'b0, 1'b1, 12);
    // One-cycle request that lands in WAKE.
    run(2'b01, 1'b0, 1'b1, 1);
    run(2'b00, 1'b0, 1'b1, 12);
    // FORCE_ON toggling: repeated wakes saturate the narrow counter.
    for (int k = 0; k < 5; k++) begin
      run(2'b00, 1'b1, 1'b1, 4);
      run(2'b00, 1'b0, 1'b1, 8);
    end
    // Reset asserted while in HOLD.
    run(2'b01, 1'b0, 1'b1, 6);
    run(2'b00, 1'b0, 1'b1, 2);
    run(2'b00, 1'b0, 1'b0, 1);
    run(2'b00, 1'b0, 1'b1, 4);
    // Randomized segments with occasional FORCE_ON and reset pulses.
    for (int k = 0; k < 80; k++) begin
      logic [1:0] r;
      logic       f;
      logic       rn;
      int         len;
      r   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) r = 2'b00;
      f   = ($urandom_range(0, 9) == 0);
      rn  = ($urandom_range(0, 24) != 0);
      len = rn ? $urandom_range(1, 9) : 1;
      run(r, f, rn, len);
    end
    run(2'b00, 1'b0, 1'b1, 3);
    @(negedge clk);
    #1;
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d entries left, expected 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
